// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate h/v raster counters with registered sync and colour for a VGA DAC.
// Latency: rgb/hsync/vsync trail x/y by one pixel (2 clks); free-running, no backpressure.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] x,
  output logic [10:0] y,
  input  logic        show,
  input  logic [7:0]  fg_color,
  input  logic [7:0]  bg_color,
  output logic [7:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pixel_tick,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        r_toggle;
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        r_hsync;
  logic        r_vsync;
  logic [7:0]  r_rgb;
  logic        r_frame_start;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_hsync_act;
  logic        w_vsync_act;
  logic        w_video_on;
  logic [7:0]  w_pix_color;

  assign w_h_last    = (r_h_cnt == H_LAST);
  assign w_v_last    = (r_v_cnt == V_LAST);
  assign w_hsync_act = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
  assign w_vsync_act = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
  assign w_video_on  = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_pix_color = w_video_on ? (show ? fg_color : bg_color) : 8'h00;

  // Divide-by-two pixel enable; the first enabled edge is the second edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_toggle <= 1'b0;
    end else begin
      r_toggle <= ~r_toggle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_toggle) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        if (w_v_last) begin
          r_v_cnt <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + 11'd1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
    end
  end

  // Sync and colour are sampled from the pixel being left, so they stay aligned with each other.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= 8'h00;
    end else if (r_toggle) begin
      r_hsync <= ~w_hsync_act;
      r_vsync <= ~w_vsync_act;
      r_rgb   <= w_pix_color;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= r_toggle & w_h_last & w_v_last;
    end
  end

  assign x           = r_h_cnt;
  assign y           = r_v_cnt;
  assign rgb         = r_rgb;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = w_video_on;
  assign pixel_tick  = r_toggle;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunk raster with random colours plus a default-timing instance.
module tb_vga_timing_gen;

  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int DHV = 640, DHF = 16, DHS = 96, DHT = 800;
  localparam int DVV = 480, DVF = 10, DVS = 2,  DVT = 525;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        s_show;
  logic [7:0]  s_fg, s_bg;
  logic [10:0] s_x, s_y;
  logic [7:0]  s_rgb;
  logic        s_hs, s_vs, s_vid, s_tick, s_fs;

  logic        d_show = 1'b1;
  logic [7:0]  d_fg = 8'hE0;
  logic [7:0]  d_bg = 8'h03;
  logic [10:0] d_x, d_y;
  logic [7:0]  d_rgb;
  logic        d_hs, d_vs, d_vid, d_tick, d_fs;

  int          n;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [7:0]  exp_rgb;
  logic [7:0]  pend_rgb;

  always #10 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .clk(clk), .rst(rst), .x(s_x), .y(s_y), .show(s_show),
    .fg_color(s_fg), .bg_color(s_bg), .rgb(s_rgb), .hsync(s_hs),
    .vsync(s_vs), .video_on(s_vid), .pixel_tick(s_tick), .frame_start(s_fs)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst), .x(d_x), .y(d_y), .show(d_show),
    .fg_color(d_fg), .bg_color(d_bg), .rgb(d_rgb), .hsync(d_hs),
    .vsync(d_vs), .video_on(d_vid), .pixel_tick(d_tick), .frame_start(d_fs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at n=%0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // Reference: after n edges since release, n/2 pixel periods have elapsed.
  function automatic bit in_win(input int c, input int lo, input int len);
    return (c >= lo) && (c < lo + len);
  endfunction

  task automatic check_all();
    int p, q, sx, sy, sxq, syq, dx, dy, dxq, dyq;
    p   = n / 2;
    q   = p - 1;
    sx  = p % SHT;         sy  = (p / SHT) % SVT;
    dx  = p % DHT;         dy  = (p / DHT) % DVT;
    sxq = (q < 0) ? 0 : q % SHT;  syq = (q < 0) ? 0 : (q / SHT) % SVT;
    dxq = (q < 0) ? 0 : q % DHT;  dyq = (q < 0) ? 0 : (q / DHT) % DVT;
    check("s_x", 32'(s_x), sx);
    check("s_y", 32'(s_y), sy);
    check("s_tick", 32'(s_tick), n % 2);
    check("s_video_on", 32'(s_vid), 32'(in_win(sx, 0, SHV) && in_win(sy, 0, SVV)));
    check("s_hsync", 32'(s_hs), 32'((q < 0) ? 1'b1 : !in_win(sxq, SHV + SHF, SHS)));
    check("s_vsync", 32'(s_vs), 32'((q < 0) ? 1'b1 : !in_win(syq, SVV + SVF, SVS)));
    check("s_rgb", 32'(s_rgb), 32'(exp_rgb));
    check("s_frame_start", 32'(s_fs), 32'((n > 0) && (n % (2 * SHT * SVT) == 0)));
    check("d_x", 32'(d_x), dx);
    check("d_y", 32'(d_y), dy);
    check("d_hsync", 32'(d_hs), 32'((q < 0) ? 1'b1 : !in_win(dxq, DHV + DHF, DHS)));
    check("d_vsync", 32'(d_vs), 32'((q < 0) ? 1'b1 : !in_win(dyq, DVV + DVF, DVS)));
    check("d_rgb", 32'(d_rgb),
          32'(((q >= 0) && in_win(dxq, 0, DHV) && in_win(dyq, 0, DVV)) ? 8'hE0 : 8'h00));
    check("d_video_on", 32'(d_vid), 32'(in_win(dx, 0, DHV) && in_win(dy, 0, DVV)));
    check("d_frame_start", 32'(d_fs), 32'((n > 0) && (n % (2 * DHT * DVT) == 0)));
  endtask

  // Inputs change every negedge; only those present at a pixel edge (n odd -> n+1) may matter.
  task automatic drive(input int mode);
    int px, py;
    if (mode == 0) begin
      s_show = 1'($urandom_range(0, 1));
      s_fg   = 8'($urandom_range(0, 255));
      s_bg   = 8'($urandom_range(0, 255));
    end else begin
      s_show = (s_x == 11'd5);
      s_fg   = 8'hE0;
      s_bg   = 8'h03;
    end
    if (n % 2 == 1) begin
      px = (n / 2) % SHT;
      py = ((n / 2) / SHT) % SVT;
      pend_rgb = (in_win(px, 0, SHV) && in_win(py, 0, SVV)) ? (s_show ? s_fg : s_bg) : 8'h00;
    end
  endtask

  task automatic step(input int mode);
    @(posedge clk);
    n++;
    if (n % 2 == 0) exp_rgb = pend_rgb;
    @(negedge clk);
    check_all();
    drive(mode);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_x"}, 32'(s_x), 0);
    check({tag, "_s_y"}, 32'(s_y), 0);
    check({tag, "_s_hsync"}, 32'(s_hs), 1);
    check({tag, "_s_vsync"}, 32'(s_vs), 1);
    check({tag, "_s_rgb"}, 32'(s_rgb), 0);
    check({tag, "_s_tick"}, 32'(s_tick), 0);
    check({tag, "_s_frame_start"}, 32'(s_fs), 0);
    check({tag, "_d_x"}, 32'(d_x), 0);
    check({tag, "_d_y"}, 32'(d_y), 0);
    check({tag, "_d_hsync"}, 32'(d_hs), 1);
    check({tag, "_d_rgb"}, 32'(d_rgb), 0);
  endtask

  initial begin
    n        = 0;
    exp_rgb  = 8'h00;
    pend_rgb = 8'h00;
    s_show   = 1'b1;
    s_fg     = 8'hE0;
    s_bg     = 8'h03;

    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b1;
    check_all();
    drive(0);

    // First 1700 clks: full default line sweep and y step; then random colours on the small raster.
    repeat (1700) step(0);
    repeat (3000) step(0);
    repeat (1200) step(1);

    for (int i = 0; i < 2100 && !(s_x == 11'd20 && s_y == 11'd7); i++) step(1);
    check("reach_reset_point", 32'(s_x == 11'd20 && s_y == 11'd7), 1);

    #2 rst = 1'b0;
    #1 check_reset("mid_frame_reset");
    repeat (3) @(negedge clk);
    check_reset("reset_held");
    rst     = 1'b1;
    n       = 0;
    exp_rgb = 8'h00;
    check_all();
    drive(1);
    repeat (300) step(1);
    repeat (2500) step(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync-pulse pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back-porch pixels; H_TOTAL = sum of the four H values (default 800).
REQ-005 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front-porch lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync-pulse lines.
REQ-008 Parameter V_BACK, default 33, vertical back-porch lines; V_TOTAL = sum of the four V values (default 525).
REQ-009 clk  input  1  system clock at 50 MHz; single clock domain.
REQ-010 rst  input  1  asynchronous active-low reset.
REQ-011 x  output  11  current horizontal pixel counter h_cnt, fed to renderers.
REQ-012 y  output  11  current vertical line counter v_cnt, fed to renderers.
REQ-013 show  input  1  OR of all renderer outputs for the current (x, y), combinational from x/y.
REQ-014 fg_color  input  8  RRRGGGBB color used where show=1.
REQ-015 bg_color  input  8  RRRGGGBB color used where show=0.
REQ-016 rgb  output  8  registered pixel color to DAC.
REQ-017 hsync  output  1  registered horizontal sync, active-low.
REQ-018 vsync  output  1  registered vertical sync, active-low.
REQ-019 video_on  output  1  combinational: 1 iff h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
REQ-020 pixel_tick  output  1  one-clk pixel enable, asserted every second clk (25 MHz rate).
REQ-021 frame_start  output  1  one-clk pulse at wrap of both counters to (0,0).

Function
REQ-022 Internal toggle bit SHALL invert every clk; pixel_tick SHALL equal toggle bit = 1.
REQ-023 h_cnt SHALL increment only on clk edges where pixel_tick=1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-024 v_cnt SHALL increment only on edges where pixel_tick=1 and h_cnt=H_TOTAL-1; at V_TOTAL-1 it SHALL wrap to 0 in the same edge as h_cnt wraps.
REQ-025 Counters SHALL never exceed H_TOTAL-1 / V_TOTAL-1; 11-bit width, no overflow for defaults.
REQ-026 Sync condition: hsync low iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751 default); vsync low iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491 default).
REQ-027 On each pixel_tick edge: hsync, vsync registered from the sync condition of the current (h_cnt, v_cnt); rgb <= video_on ? (show ? fg_color : bg_color) : 8'h00.
REQ-028 rgb, hsync, vsync SHALL lag x/y by exactly one pixel period (2 clks), mutually aligned; all hold between pixel_ticks.
REQ-029 frame_start SHALL be registered, high for exactly one clk following the edge where h_cnt wraps from H_TOTAL-1 and v_cnt wraps from V_TOTAL-1.
REQ-030 rgb SHALL be 8'h00 during all blanking pixels regardless of show, fg_color, bg_color.
REQ-031 Line period SHALL be 2*H_TOTAL clks (1600); frame period 2*H_TOTAL*V_TOTAL clks (840000).

Reset
REQ-032 While rst=0: toggle bit 0, h_cnt 0, v_cnt 0, hsync 1, vsync 1, rgb 8'h00, frame_start 0, asynchronously.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; after release, first pixel_tick occurs on the first clk edge, counting resumes from (0,0), and no frame_start pulse is produced until a full frame completes.

Verification
REQ-034 Release reset, run 1600 clks -> x sweeps 0..799 once, each value for 2 clks; y increments 0->1 exactly at x wrap.
REQ-035 Run one frame -> hsync low for 192 clks per line starting 2 clks after x=656; vsync low 2 lines starting one pixel after (x=0,y=490); frame_start pulses once after 840000 clks.
REQ-036 show=1, fg=8'hE0, bg=8'h03 -> rgb=8'hE0 for visible pixels, 8'h00 at x>=640 or y>=480, one pixel after the matching x/y.
REQ-037 Toggle show at x=100 only -> rgb=fg_color solely for the pixel registered from x=100, output during x=101.
REQ-038 Assert rst at (x=300,y=200) -> outputs reset immediately; after release x=0,y=0, hsync=vsync=1, no frame_start for 840000 clks.
